// File: rtl/count_seq_monitor.sv
// Purpose: checks a sampled count bus against a binary up-count, tracks lock, loss-of-lock and wraps.
// Latency: one cycle; a sample accepted at edge n is reflected on all outputs right after edge n.
// Backpressure: none; samples are qualified by sample_en and the block always accepts them.
module count_seq_monitor #(
  parameter int WIDTH    = 3,
  parameter int LOCK_LEN = 4,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              sample_en,
  input  logic [WIDTH-1:0]  count_in,
  output logic              locked,
  output logic              err,
  output logic [3:0]        err_count,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  last_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_LEN);

  state_t              state, state_nxt;
  logic [3:0]          run_len, run_len_nxt;
  logic                err_nxt;
  logic [3:0]          err_count_nxt;
  logic                wrap_pulse_nxt;
  logic [WRAP_W-1:0]   wrap_count_nxt;
  logic [WIDTH-1:0]    last_count_nxt;
  logic                match;

  // last_count doubles as the previous sample; a stall or skip both fail this compare
  assign match = (count_in == (last_count + WIDTH'(1)));

  // State register; clr wins over any sample in the same cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output decode for one accepted sample
  always_comb begin
    state_nxt      = state;
    run_len_nxt    = run_len;
    err_nxt        = err;
    err_count_nxt  = err_count;
    wrap_pulse_nxt = 1'b0;
    wrap_count_nxt = wrap_count;
    last_count_nxt = last_count;

    if (sample_en) begin
      last_count_nxt = count_in;
      case (state)
        IDLE: begin
          // First sample only seeds the reference value
          state_nxt   = ACQUIRE;
          run_len_nxt = 4'd0;
        end
        ACQUIRE, FAULT: begin
          if (match) begin
            if ((run_len + 4'd1) == LOCK_TGT) begin
              // Lock-completing step never pulses wrap, even on max->0
              state_nxt   = LOCKED;
              run_len_nxt = 4'd0;
            end else begin
              run_len_nxt = run_len + 4'd1;
            end
          end else begin
            run_len_nxt = 4'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            if (count_in == '0) begin
              wrap_pulse_nxt = 1'b1;
              wrap_count_nxt = wrap_count + WRAP_W'(1);
            end
          end else begin
            state_nxt     = FAULT;
            run_len_nxt   = 4'd0;
            err_nxt       = 1'b1;
            err_count_nxt = (err_count == 4'hF) ? err_count : (err_count + 4'd1);
          end
        end
        default: begin
          state_nxt   = IDLE;
          run_len_nxt = 4'd0;
        end
      endcase
    end
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (clr) begin
      run_len    <= 4'd0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_count  <= 4'd0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      last_count <= '0;
    end else begin
      run_len    <= run_len_nxt;
      locked     <= (state_nxt == LOCKED);
      err        <= err_nxt;
      err_count  <= err_count_nxt;
      wrap_pulse <= wrap_pulse_nxt;
      wrap_count <= wrap_count_nxt;
      last_count <= last_count_nxt;
    end
  end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Purpose: directed self-checking bench for count_seq_monitor.
// Latency: outputs sampled 1ns after each rising edge that consumed a stimulus.
// Backpressure: not applicable; stimulus is driven one sample per cycle.
module tb_count_seq_monitor;

  logic       clk;
  logic       clr;
  logic       sample_en;
  logic [2:0] count_in;
  logic       locked;
  logic       err;
  logic [3:0] err_count;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic [2:0] last_count;

  int checks;
  int failures;

  count_seq_monitor #(
    .WIDTH(3),
    .LOCK_LEN(4),
    .WRAP_W(8)
  ) dut (
    .clk(clk),
    .clr(clr),
    .sample_en(sample_en),
    .count_in(count_in),
    .locked(locked),
    .err(err),
    .err_count(err_count),
    .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count),
    .last_count(last_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic en, input logic [2:0] v);
    sample_en = en;
    count_in  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr(input int n);
    clr       = 1'b1;
    sample_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    // clr held with a live sample: clr must win
    clr       = 1'b1;
    sample_en = 1'b1;
    count_in  = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    clr       = 1'b0;
    sample_en = 1'b0;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (err_count !== 4'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL reset_wrap_pulse got=%b exp=0", wrap_pulse); end
    checks++; if (wrap_count !== 8'd0) begin failures++; $display("FAIL reset_wrap_count got=%0d exp=0", wrap_count); end
    checks++; if (last_count !== 3'd0) begin failures++; $display("FAIL reset_last_count got=%0d exp=0", last_count); end
  endtask

  task automatic test_lock_wrap();
    logic [2:0] v;
    do_clr(2);
    for (int i = 0; i < 10; i++) begin
      v = 3'(i % 8);
      step(1'b1, v);
      checks++; if (locked !== (i >= 4)) begin failures++; $display("FAIL lockwrap_locked idx=%0d got=%b exp=%b", i, locked, (i >= 4)); end
      checks++; if (wrap_pulse !== (i == 8)) begin failures++; $display("FAIL lockwrap_pulse idx=%0d got=%b exp=%b", i, wrap_pulse, (i == 8)); end
      checks++; if (last_count !== v) begin failures++; $display("FAIL lockwrap_last idx=%0d got=%0d exp=%0d", i, last_count, v); end
    end
    checks++; if (wrap_count !== 8'd1) begin failures++; $display("FAIL lockwrap_wrap_count got=%0d exp=1", wrap_count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL lockwrap_err got=%b exp=0", err); end
  endtask

  task automatic test_prelock_glitch();
    int vals [8] = '{0, 1, 2, 5, 6, 7, 0, 1};
    do_clr(1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(vals[i]));
      checks++; if (locked !== (i == 7)) begin failures++; $display("FAIL glitch_locked idx=%0d got=%b exp=%b", i, locked, (i == 7)); end
      checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL glitch_pulse idx=%0d got=%b exp=0", i, wrap_pulse); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL glitch_err idx=%0d got=%b exp=0", i, err); end
    end
    checks++; if (wrap_count !== 8'd0) begin failures++; $display("FAIL glitch_wrap_count got=%0d exp=0", wrap_count); end
  endtask

  task automatic test_loss_of_lock();
    int vals   [10] = '{7, 0, 1, 2, 3, 3, 4, 5, 6, 7};
    int exp_lk [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int exp_er [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    do_clr(1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'(vals[i]));
      checks++; if (locked !== exp_lk[i][0]) begin failures++; $display("FAIL lol_locked idx=%0d got=%b exp=%0d", i, locked, exp_lk[i]); end
      checks++; if (err !== exp_er[i][0]) begin failures++; $display("FAIL lol_err idx=%0d got=%b exp=%0d", i, err, exp_er[i]); end
      checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL lol_pulse idx=%0d got=%b exp=0", i, wrap_pulse); end
    end
    checks++; if (err_count !== 4'd1) begin failures++; $display("FAIL lol_err_count got=%0d exp=1", err_count); end
    checks++; if (wrap_count !== 8'd0) begin failures++; $display("FAIL lol_wrap_count got=%0d exp=0", wrap_count); end
  endtask

  task automatic test_gaps();
    logic [2:0] v;
    do_clr(1);
    for (int k = 0; k < 12; k++) begin
      v = 3'(k % 8);
      step(1'b1, v);
      checks++; if (locked !== (k >= 4)) begin failures++; $display("FAIL gaps_locked k=%0d got=%b exp=%b", k, locked, (k >= 4)); end
      checks++; if (wrap_pulse !== (k == 8)) begin failures++; $display("FAIL gaps_pulse k=%0d got=%b exp=%b", k, wrap_pulse, (k == 8)); end
      // Garbage value on an idle cycle must be ignored entirely
      step(1'b0, 3'(k + 3));
      checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL gaps_idle_pulse k=%0d got=%b exp=0", k, wrap_pulse); end
      checks++; if (last_count !== v) begin failures++; $display("FAIL gaps_idle_last k=%0d got=%0d exp=%0d", k, last_count, v); end
      checks++; if (locked !== (k >= 4)) begin failures++; $display("FAIL gaps_idle_locked k=%0d got=%b exp=%b", k, locked, (k >= 4)); end
    end
    checks++; if (wrap_count !== 8'd1) begin failures++; $display("FAIL gaps_wrap_count got=%0d exp=1", wrap_count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL gaps_err got=%b exp=0", err); end
  endtask

  task automatic test_saturation_and_reset();
    logic [2:0] v;
    int exp_ec;
    do_clr(1);
    v = 3'd0;
    step(1'b1, v);
    for (int n = 1; n <= 20; n++) begin
      repeat (4) begin
        v = v + 3'd1;
        step(1'b1, v);
        checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL sat_pulse n=%0d got=%b exp=0", n, wrap_pulse); end
      end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sat_locked n=%0d got=%b exp=1", n, locked); end
      step(1'b1, v);
      exp_ec = (n > 15) ? 15 : n;
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL sat_unlocked n=%0d got=%b exp=0", n, locked); end
      checks++; if (err_count !== 4'(exp_ec)) begin failures++; $display("FAIL sat_err_count n=%0d got=%0d exp=%0d", n, err_count, exp_ec); end
    end
    checks++; if (wrap_count !== 8'd0) begin failures++; $display("FAIL sat_wrap_count got=%0d exp=0", wrap_count); end

    // Relock so the reset below happens while LOCKED with err set
    repeat (4) begin
      v = v + 3'd1;
      step(1'b1, v);
    end
    checks++; if (locked !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL midrun_pre locked=%b err=%b exp=1,1", locked, err); end
    clr       = 1'b1;
    sample_en = 1'b1;
    count_in  = v + 3'd1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL midrun_locked got=%b exp=0", locked); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL midrun_err got=%b exp=0", err); end
    checks++; if (err_count !== 4'd0) begin failures++; $display("FAIL midrun_err_count got=%0d exp=0", err_count); end
    checks++; if (last_count !== 3'd0) begin failures++; $display("FAIL midrun_last got=%0d exp=0", last_count); end
    checks++; if (wrap_count !== 8'd0 || wrap_pulse !== 1'b0) begin failures++; $display("FAIL midrun_wrap got=%0d/%b exp=0/0", wrap_count, wrap_pulse); end

    // 5 is a skip from the reset value 0 but must take the IDLE path silently
    step(1'b1, 3'd5);
    checks++; if (err !== 1'b0 || locked !== 1'b0) begin failures++; $display("FAIL postclr_first err=%b locked=%b exp=0,0", err, locked); end
    checks++; if (last_count !== 3'd5) begin failures++; $display("FAIL postclr_last got=%0d exp=5", last_count); end
    step(1'b1, 3'd6);
    step(1'b1, 3'd7);
    step(1'b1, 3'd0);
    checks++; if (wrap_pulse !== 1'b0 || locked !== 1'b0) begin failures++; $display("FAIL postclr_prelock pulse=%b locked=%b exp=0,0", wrap_pulse, locked); end
    step(1'b1, 3'd1);
    checks++; if (locked !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL postclr_lock locked=%b err=%b exp=1,0", locked, err); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    clr       = 1'b0;
    sample_en = 1'b0;
    count_in  = 3'd0;
    test_reset();
    test_lock_wrap();
    test_prelock_glitch();
    test_loss_of_lock();
    test_gaps();
    test_saturation_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
